sim_memory_arbiter: RTL and testbench

Two-port arbiter that shares the single simulation memory model port between two requesters, port 0 (instruction fetch) and port 1 (data load/store). It grants one request per cycle, round-robin, and records the issuing port of every accepted read in a tag FIFO. It uses that FIFO to route the in-order 64-bit read responses back to the correct requester. It sits between the core's bus masters and the memory model in the simulation top.

---
 rtl/sim_memory_arbiter_pkg.sv | 16 +
 rtl/sim_memory_arbiter_tag_fifo.sv | 55 +++++
 rtl/sim_memory_arbiter.sv | 127 ++++++++++++
 tb/tb_sim_memory_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_memory_arbiter_pkg.sv
// rtl/sim_memory_arbiter_pkg.sv - shared encodings for the simulation memory arbiter
package sim_memory_arbiter_pkg;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_BAD  = 2'b11;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    function automatic logic order_illegal(input logic [1:0] order);
        return order == ORDER_BAD;
    endfunction

endpackage

// File: rtl/sim_memory_arbiter_tag_fifo.sv
// rtl/sim_memory_arbiter_tag_fifo.sv - 1-bit tag FIFO holding the issuing port of each outstanding read
module sim_memory_arbiter_tag_fifo #(
    parameter int P_TAG_DEPTH   = 8,
    parameter int P_TAG_DEPTH_N = 3
) (
    input  logic iCLOCK,
    input  logic iRESET,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    logic [P_TAG_DEPTH-1:0]   storage;
    logic [P_TAG_DEPTH_N-1:0] wr_ptr;
    logic [P_TAG_DEPTH_N-1:0] rd_ptr;
    logic [P_TAG_DEPTH_N:0]   count;
    logic                     do_push;
    logic                     do_pop;

    localparam logic [P_TAG_DEPTH_N-1:0] LAST_PTR = P_TAG_DEPTH_N'(P_TAG_DEPTH - 1);
    localparam logic [P_TAG_DEPTH_N:0]   FULL_CNT = (P_TAG_DEPTH_N + 1)'(P_TAG_DEPTH);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = storage[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            storage <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= push_tag;
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            // simultaneous push and pop leaves occupancy untouched
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sim_memory_arbiter.sv
// rtl/sim_memory_arbiter.sv - round-robin two-port arbiter in front of the simulation memory model
module sim_memory_arbiter
    import sim_memory_arbiter_pkg::*;
#(
    parameter int P_TAG_DEPTH   = 8,
    parameter int P_TAG_DEPTH_N = 3
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iP0_REQ,
    output logic        oP0_LOCK,
    input  logic [1:0]  iP0_ORDER,
    input  logic        iP0_RW,
    input  logic [25:0] iP0_ADDR,
    input  logic [31:0] iP0_DATA,
    output logic        oP0_VALID,
    input  logic        iP0_LOCK,
    output logic [63:0] oP0_DATA,
    input  logic        iP1_REQ,
    output logic        oP1_LOCK,
    input  logic [1:0]  iP1_ORDER,
    input  logic        iP1_RW,
    input  logic [25:0] iP1_ADDR,
    input  logic [31:0] iP1_DATA,
    output logic        oP1_VALID,
    input  logic        iP1_LOCK,
    output logic [63:0] oP1_DATA,
    output logic        oMEM_REQ,
    output logic [1:0]  oMEM_ORDER,
    output logic        oMEM_RW,
    output logic [25:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_LOCK,
    input  logic        iMEM_VALID,
    output logic        oMEM_LOCK,
    input  logic [63:0] iMEM_DATA,
    output logic        oERROR
);

    logic rr_last;
    logic p0_elig;
    logic p1_elig;
    logic grant0;
    logic grant1;
    logic accept;
    logic tag_push;
    logic tag_pop;
    logic tag_full;
    logic tag_empty;
    logic tag_head;
    logic error_event;

    // reads are held off while the tag FIFO cannot record them; writes need no tag
    assign p0_elig = iP0_REQ & ~(~iP0_RW & tag_full);
    assign p1_elig = iP1_REQ & ~(~iP1_RW & tag_full);

    assign grant0 = p0_elig & (~p1_elig | (rr_last == PORT_DATA));
    assign grant1 = p1_elig & ~grant0;

    always_comb begin
        oMEM_REQ   = 1'b0;
        oMEM_ORDER = '0;
        oMEM_RW    = 1'b0;
        oMEM_ADDR  = '0;
        oMEM_DATA  = '0;
        if (grant0) begin
            oMEM_REQ   = 1'b1;
            oMEM_ORDER = iP0_ORDER;
            oMEM_RW    = iP0_RW;
            oMEM_ADDR  = iP0_ADDR;
            oMEM_DATA  = iP0_DATA;
        end else if (grant1) begin
            oMEM_REQ   = 1'b1;
            oMEM_ORDER = iP1_ORDER;
            oMEM_RW    = iP1_RW;
            oMEM_ADDR  = iP1_ADDR;
            oMEM_DATA  = iP1_DATA;
        end
    end

    assign oP0_LOCK = iP0_REQ & ~(grant0 & ~iMEM_LOCK);
    assign oP1_LOCK = iP1_REQ & ~(grant1 & ~iMEM_LOCK);

    assign accept   = (grant0 | grant1) & ~iMEM_LOCK;
    assign tag_push = accept & ~oMEM_RW;
    assign tag_pop  = iMEM_VALID & ~tag_empty;

    sim_memory_arbiter_tag_fifo #(
        .P_TAG_DEPTH   (P_TAG_DEPTH),
        .P_TAG_DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .iCLOCK   (iCLOCK),
        .iRESET   (iRESET),
        .push     (tag_push),
        .push_tag (grant1),
        .pop      (tag_pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

    // response routing follows the oldest outstanding read
    assign oMEM_LOCK = tag_empty ? 1'b1 : (tag_head ? iP1_LOCK : iP0_LOCK);
    assign oP0_VALID = tag_pop & (tag_head == PORT_IFETCH);
    assign oP1_VALID = tag_pop & (tag_head == PORT_DATA);
    assign oP0_DATA  = iMEM_DATA;
    assign oP1_DATA  = iMEM_DATA;

    assign error_event = (iMEM_VALID & tag_empty)
                       | (iP0_REQ & order_illegal(iP0_ORDER))
                       | (iP1_REQ & order_illegal(iP1_ORDER));

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rr_last <= PORT_DATA;
            oERROR  <= 1'b0;
        end else begin
            if (accept) begin
                rr_last <= grant1 ? PORT_DATA : PORT_IFETCH;
            end
            if (error_event) begin
                oERROR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_memory_arbiter.sv
// tb/tb_sim_memory_arbiter.sv - directed self-checking bench for sim_memory_arbiter
module tb_sim_memory_arbiter;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iP0_REQ, iP0_RW, iP0_LOCK, oP0_LOCK, oP0_VALID;
    logic [1:0]  iP0_ORDER;
    logic [25:0] iP0_ADDR;
    logic [31:0] iP0_DATA;
    logic [63:0] oP0_DATA;
    logic        iP1_REQ, iP1_RW, iP1_LOCK, oP1_LOCK, oP1_VALID;
    logic [1:0]  iP1_ORDER;
    logic [25:0] iP1_ADDR;
    logic [31:0] iP1_DATA;
    logic [63:0] oP1_DATA;
    logic        oMEM_REQ, oMEM_RW, iMEM_LOCK, iMEM_VALID, oMEM_LOCK, oERROR;
    logic [1:0]  oMEM_ORDER;
    logic [25:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic [63:0] iMEM_DATA;

    int total = 0;
    int bad   = 0;

    // memory model: reads capture data on acceptance and return in order
    logic [63:0] mem [0:31];
    logic [63:0] mq  [0:15];
    logic [3:0]  mq_wr = '0;
    logic [3:0]  mq_rd = '0;
    logic        resp_en = 1'b1;
    logic        inj_valid = 1'b0;

    int   g_port [0:255];
    int   g_n = 0;
    int   r_port [0:255];
    logic [63:0] r_data [0:255];
    int   r_n = 0;
    int   gb, rb;

    sim_memory_arbiter dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET),
        .iP0_REQ(iP0_REQ), .oP0_LOCK(oP0_LOCK), .iP0_ORDER(iP0_ORDER), .iP0_RW(iP0_RW),
        .iP0_ADDR(iP0_ADDR), .iP0_DATA(iP0_DATA), .oP0_VALID(oP0_VALID), .iP0_LOCK(iP0_LOCK),
        .oP0_DATA(oP0_DATA),
        .iP1_REQ(iP1_REQ), .oP1_LOCK(oP1_LOCK), .iP1_ORDER(iP1_ORDER), .iP1_RW(iP1_RW),
        .iP1_ADDR(iP1_ADDR), .iP1_DATA(iP1_DATA), .oP1_VALID(oP1_VALID), .iP1_LOCK(iP1_LOCK),
        .oP1_DATA(oP1_DATA),
        .oMEM_REQ(oMEM_REQ), .oMEM_ORDER(oMEM_ORDER), .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR),
        .oMEM_DATA(oMEM_DATA), .iMEM_LOCK(iMEM_LOCK), .iMEM_VALID(iMEM_VALID),
        .oMEM_LOCK(oMEM_LOCK), .iMEM_DATA(iMEM_DATA), .oERROR(oERROR)
    );

    always #5 iCLOCK = ~iCLOCK;

    assign iMEM_VALID = (resp_en && (mq_wr != mq_rd) && !oMEM_LOCK) || inj_valid;
    assign iMEM_DATA  = mq[mq_rd];

    function automatic logic [63:0] word(input int i);
        if (i == 1) return 64'h1122334455667788;
        return {32'hC0DE0000 + 32'(i), 32'h00001000 + 32'(i)};
    endfunction

    always @(posedge iCLOCK) begin
        if (iRESET) begin
            mq_wr <= '0;
            mq_rd <= '0;
        end else begin
            if (oMEM_REQ && !iMEM_LOCK && !oMEM_RW) begin
                mq[mq_wr] <= mem[oMEM_ADDR[7:3]];
                mq_wr     <= mq_wr + 1'b1;
            end
            if (iMEM_VALID && (mq_wr != mq_rd)) mq_rd <= mq_rd + 1'b1;
        end
        if (iP0_REQ && !oP0_LOCK) begin
            g_port[g_n] <= 0;
            g_n         <= g_n + 1;
        end else if (iP1_REQ && !oP1_LOCK) begin
            g_port[g_n] <= 1;
            g_n         <= g_n + 1;
        end
        if (oP0_VALID) begin
            r_port[r_n] <= 0;
            r_data[r_n] <= oP0_DATA;
            r_n         <= r_n + 1;
        end else if (oP1_VALID) begin
            r_port[r_n] <= 1;
            r_data[r_n] <= oP1_DATA;
            r_n         <= r_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic p0(input logic req, input logic rw, input logic [1:0] ord,
                      input logic [25:0] addr, input logic [31:0] data);
        iP0_REQ = req; iP0_RW = rw; iP0_ORDER = ord; iP0_ADDR = addr; iP0_DATA = data;
    endtask

    task automatic p1(input logic req, input logic rw, input logic [1:0] ord,
                      input logic [25:0] addr, input logic [31:0] data);
        iP1_REQ = req; iP1_RW = rw; iP1_ORDER = ord; iP1_ADDR = addr; iP1_DATA = data;
    endtask

    task automatic do_reset();
        @(negedge iCLOCK);
        iRESET = 1'b1;
        @(negedge iCLOCK);
        iRESET = 1'b0;
    endtask

    task automatic mark();
        gb = g_n;
        rb = r_n;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word(i);
        iRESET = 1'b1; iMEM_LOCK = 1'b0; iP0_LOCK = 1'b0; iP1_LOCK = 1'b0;
        p0(0, 0, 2'b10, '0, '0);
        p1(0, 0, 2'b10, '0, '0);
        repeat (2) @(negedge iCLOCK);
        #1;
        chk("rst_error", oERROR, 0);
        chk("rst_memlock", oMEM_LOCK, 1);
        chk("rst_valid0", oP0_VALID, 0);
        chk("rst_valid1", oP1_VALID, 0);
        chk("rst_memreq", oMEM_REQ, 0);
        chk("rst_lock0", oP0_LOCK, 0);
        iRESET = 1'b0;

        // single read
        @(negedge iCLOCK);
        mark();
        p0(1, 0, 2'b10, 26'h8, '0);
        #1;
        chk("rd_lock0", oP0_LOCK, 0);
        chk("rd_memreq", oMEM_REQ, 1);
        chk("rd_addr", oMEM_ADDR, 26'h8);
        chk("rd_order", oMEM_ORDER, 2'b10);
        @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        repeat (4) @(negedge iCLOCK);
        chk("rd_grants", g_n - gb, 1);
        chk("rd_nresp", r_n - rb, 1);
        chk("rd_port", r_port[rb], 0);
        chk("rd_data", r_data[rb], 64'h1122334455667788);

        // fairness
        do_reset();
        mark();
        p0(1, 0, 2'b10, 26'h10, '0);
        p1(1, 0, 2'b10, 26'h18, '0);
        repeat (6) @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        p1(0, 0, 2'b10, '0, '0);
        repeat (4) @(negedge iCLOCK);
        chk("rr_ngrant", g_n - gb, 6);
        chk("rr_nresp", r_n - rb, 6);
        for (int i = 0; i < 6; i++) begin
            chk("rr_gport", g_port[gb + i], i % 2);
            chk("rr_rport", r_port[rb + i], i % 2);
            chk("rr_rdata", r_data[rb + i], word(2 + i % 2));
        end

        // tag full
        do_reset();
        mark();
        iP0_LOCK = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p0(1, 0, 2'b10, 26'((4 + i) * 8), '0);
            @(negedge iCLOCK);
        end
        p0(1, 0, 2'b10, 26'(12 * 8), '0);
        p1(1, 1, 2'b00, 26'h3, 32'hAB);
        #1;
        chk("full_lock0", oP0_LOCK, 1);
        chk("full_lock1", oP1_LOCK, 0);
        chk("full_wr_rw", oMEM_RW, 1);
        chk("full_wr_addr", oMEM_ADDR, 26'h3);
        chk("full_wr_data", oMEM_DATA, 32'hAB);
        chk("full_wr_ord", oMEM_ORDER, 2'b00);
        @(negedge iCLOCK);
        p1(0, 0, 2'b10, '0, '0);
        #1;
        chk("full_lock0_b", oP0_LOCK, 1);
        chk("full_noreq", oMEM_REQ, 0);
        iP0_LOCK = 1'b0;
        @(negedge iCLOCK);
        #1;
        chk("full_9th_acc", oP0_LOCK, 0);
        @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        repeat (12) @(negedge iCLOCK);
        chk("full_ngrant", g_n - gb, 10);
        chk("full_nresp", r_n - rb, 9);
        for (int i = 0; i < 9; i++) begin
            chk("full_rport", r_port[rb + i], 0);
            chk("full_rdata", r_data[rb + i], word(4 + i));
        end

        // back-pressure
        do_reset();
        mark();
        resp_en = 1'b0;
        p0(1, 0, 2'b10, 26'h10, '0);
        @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        p1(1, 0, 2'b10, 26'h18, '0);
        @(negedge iCLOCK);
        p1(0, 0, 2'b10, '0, '0);
        iP0_LOCK = 1'b1;
        resp_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_memlock", oMEM_LOCK, 1);
            chk("bp_valid1", oP1_VALID, 0);
            chk("bp_valid0", oP0_VALID, 0);
            @(negedge iCLOCK);
        end
        iP0_LOCK = 1'b0;
        repeat (4) @(negedge iCLOCK);
        chk("bp_nresp", r_n - rb, 2);
        chk("bp_port_a", r_port[rb], 0);
        chk("bp_data_a", r_data[rb], word(2));
        chk("bp_port_b", r_port[rb + 1], 1);
        chk("bp_data_b", r_data[rb + 1], word(3));

        // simultaneous push and pop at count 4
        do_reset();
        mark();
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p0(1, 0, 2'b10, 26'((4 + i) * 8), '0);
            @(negedge iCLOCK);
        end
        resp_en = 1'b1;
        p0(1, 0, 2'b10, 26'(8 * 8), '0);
        #1;
        chk("pp_valid0", oP0_VALID, 1);
        chk("pp_lock0", oP0_LOCK, 0);
        @(negedge iCLOCK);
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p0(1, 0, 2'b10, 26'((9 + i) * 8), '0);
            #1;
            chk("pp_fill", oP0_LOCK, 0);
            @(negedge iCLOCK);
        end
        p0(1, 0, 2'b10, 26'(13 * 8), '0);
        #1;
        chk("pp_full", oP0_LOCK, 1);
        @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        resp_en = 1'b1;
        repeat (12) @(negedge iCLOCK);
        chk("pp_nresp", r_n - rb, 9);
        chk("pp_first", r_data[rb], word(4));
        chk("pp_head", r_data[rb + 1], word(5));
        chk("pp_last", r_data[rb + 8], word(12));

        // error and reset
        do_reset();
        mark();
        inj_valid = 1'b1;
        #1;
        chk("err_valid0", oP0_VALID, 0);
        chk("err_valid1", oP1_VALID, 0);
        @(negedge iCLOCK);
        inj_valid = 1'b0;
        #1;
        chk("err_set", oERROR, 1);
        resp_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p0(1, 0, 2'b10, 26'((2 + i) * 8), '0);
            @(negedge iCLOCK);
        end
        p0(0, 0, 2'b10, '0, '0);
        #1;
        chk("err_sticky", oERROR, 1);
        chk("err_pending", oMEM_LOCK, 0);
        #1;
        iRESET = 1'b1;
        @(negedge iCLOCK);
        #1;
        chk("rst2_error", oERROR, 0);
        chk("rst2_empty", oMEM_LOCK, 1);
        iRESET  = 1'b0;
        resp_en = 1'b1;
        @(negedge iCLOCK);
        p0(1, 0, 2'b10, 26'h10, '0);
        p1(1, 0, 2'b10, 26'h18, '0);
        #1;
        chk("rst2_grant0", oP0_LOCK, 0);
        chk("rst2_lock1", oP1_LOCK, 1);
        @(negedge iCLOCK);
        p0(0, 0, 2'b10, '0, '0);
        p1(0, 0, 2'b10, '0, '0);
        repeat (4) @(negedge iCLOCK);
        chk("rst2_noerr", oERROR, 0);
        p1(1, 1, 2'b11, 26'h20, 32'h5);
        @(negedge iCLOCK);
        p1(0, 0, 2'b10, '0, '0);
        #1;
        chk("err_order", oERROR, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
